// File: rtl/mul_accum_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul_accum_seq
// Description : Multiply-accumulate sequencer around an external shift-add
//               multiplier. Takes operand pairs over valid/ready, launches
//               one multiply per pair, accumulates the products and emits
//               the group sum, pair count and overflow flag when the pair
//               marked last has been accumulated.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_accum_seq #(
  parameter int W     = 8,
  parameter int ACC_W = 20,
  parameter int LEN_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  // operand stream
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic               in_last,
  // multiplier side
  output logic               mul_start,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  input  logic               mul_done,
  input  logic [2*W-1:0]     mul_p,
  // group result
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [LEN_W-1:0]   out_count,
  output logic               out_ovf
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_ACC       = 3'd4,
    S_OUT       = 3'd5
  } state_t;

  localparam logic [LEN_W-1:0] C_CNT_MAX = '1;
  localparam logic [LEN_W-1:0] C_CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t             state_q,     state_d;
  logic [ACC_W-1:0]   acc_q,       acc_d;
  logic [LEN_W-1:0]   cnt_q,       cnt_d;
  logic               ovf_q,       ovf_d;
  logic [W-1:0]       mul_a_q,     mul_a_d;
  logic [W-1:0]       mul_b_q,     mul_b_d;
  logic               last_q,      last_d;
  logic               mul_start_q, mul_start_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q,   out_sum_d;
  logic [LEN_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q,   out_ovf_d;

  // Accumulate one bit wider than the accumulator so the carry-out is the
  // overflow indication; the product is zero-extended.
  logic [ACC_W:0]     w_acc_sum;
  logic               w_cnt_sat;
  logic [LEN_W-1:0]   w_cnt_inc;
  logic               w_ovf_next;

  assign w_acc_sum  = {1'b0, acc_q} + {{(ACC_W+1-2*W){1'b0}}, mul_p};
  assign w_cnt_sat  = (cnt_q == C_CNT_MAX);
  assign w_cnt_inc  = w_cnt_sat ? cnt_q : (cnt_q + C_CNT_ONE);
  assign w_ovf_next = ovf_q | w_acc_sum[ACC_W] | w_cnt_sat;

  // Next-state and next-value decode for the whole sequencer.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    last_d      = last_q;
    mul_start_d = 1'b0;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mul_a_d     = in_a;
          mul_b_d     = in_b;
          last_d      = in_last;
          mul_start_d = 1'b1;   // start pulse is high exactly during START
          state_d     = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // The multiplier acknowledges the start by dropping its done flag.
        if (!mul_done) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (mul_done) begin
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        acc_d = w_acc_sum[ACC_W-1:0];
        cnt_d = w_cnt_inc;
        ovf_d = w_ovf_next;
        if (last_q) begin
          out_sum_d   = w_acc_sum[ACC_W-1:0];
          out_count_d = w_cnt_inc;
          out_ovf_d   = w_ovf_next;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OUT: begin
        // Result registers keep their value after the handshake; only the
        // running group state is cleared.
        if (out_ready) begin
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      last_q      <= 1'b0;
      mul_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      last_q      <= last_d;
      mul_start_q <= mul_start_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_accum_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_accum_seq
// Description : Bench for mul_accum_seq with a behavioural multiplier and a
//               group-level reference model (plain arithmetic over pairs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_accum_seq;

  localparam int W     = 8;
  localparam int ACC_W = 16;
  localparam int LEN_W = 2;
  localparam longint ACC_MOD = 64'd1 << ACC_W;
  localparam int CMAX  = (1 << LEN_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [W-1:0]       in_a = '0;
  logic [W-1:0]       in_b = '0;
  logic               in_last = 1'b0;
  logic               mul_start;
  logic [W-1:0]       mul_a;
  logic [W-1:0]       mul_b;
  logic               mul_done;
  logic [2*W-1:0]     mul_p;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [ACC_W-1:0]   out_sum;
  logic [LEN_W-1:0]   out_count;
  logic               out_ovf;

  int ntests = 0;
  int nfail  = 0;

  mul_accum_seq #(.W(W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_done  (mul_done),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    ntests++;
    nfail++;
    $display("FAIL %s: timed out waiting on DUT (t=%0t)", name, $time);
  endtask

  // Behavioural multiplier: done drops the cycle after start is sampled,
  // stays low for 1..5 cycles, junk on mul_p while busy.
  logic [2*W-1:0] prod_r;
  int             busy_left;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_done  <= 1'b1;
      mul_p     <= '0;
      prod_r    <= '0;
      busy_left <= 0;
    end else if (mul_start && mul_done) begin
      mul_done  <= 1'b0;
      busy_left <= $urandom_range(0, 4);
      prod_r    <= mul_a * mul_b;
    end else if (!mul_done) begin
      if (busy_left == 0) begin
        mul_done <= 1'b1;
        mul_p    <= prod_r;
      end else begin
        busy_left <= busy_left - 1;
        mul_p     <= (2*W)'($urandom);
      end
    end
  end

  // Consumer ready: random in random mode, otherwise the forced level.
  bit rand_mode    = 1'b0;
  bit forced_ready = 1'b1;
  always @(negedge clk) begin
    #1 out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : forced_ready;
  end

  // Reference model: a group's expected result is the plain sum of products
  // of its pairs, reduced mod 2^ACC_W, with the count clamped.
  typedef struct {
    longint sum;
    longint count;
    longint ovf;
  } res_t;
  res_t   exp_q[$];
  longint m_sum = 0;
  int     m_n = 0;
  int     handshakes = 0;
  int     pulses = 0;
  logic [W-1:0] last_a = '0;
  logic [W-1:0] last_b = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sum = 0;
      m_n   = 0;
      exp_q.delete();
    end else begin
      if (mul_start) pulses++;
      if (in_valid && in_ready) begin
        res_t r;
        handshakes++;
        last_a = in_a;
        last_b = in_b;
        m_sum += longint'(in_a) * longint'(in_b);
        m_n++;
        if (in_last) begin
          r.sum   = m_sum % ACC_MOD;
          r.count = (m_n > CMAX) ? CMAX : m_n;
          r.ovf   = ((m_sum >= ACC_MOD) || (m_n > CMAX)) ? 1 : 0;
          exp_q.push_back(r);
          m_sum = 0;
          m_n   = 0;
        end
      end
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  // Per-cycle compare against the model.
  bit prev_start = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (mul_start) begin
        chk("mul_a_at_start", mul_a, last_a);
        chk("mul_b_at_start", mul_b, last_b);
        chk("start_single_cycle", prev_start, 0);
      end
      if (!mul_done || mul_start) chk("in_ready_while_busy", in_ready, 0);
      if (out_valid) begin
        chk("in_ready_in_out", in_ready, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 0);
        end else begin
          chk("out_sum", out_sum, exp_q[0].sum);
          chk("out_count", out_count, exp_q[0].count);
          chk("out_ovf", out_ovf, exp_q[0].ovf);
        end
      end
    end
    prev_start = mul_start;
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b, input bit last);
    int n = 0;
    in_a = a;
    in_b = b;
    in_last = last;
    in_valid = 1'b1;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_timeout("send_pair");
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input string name);
    int n = 0;
    while (!out_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_timeout(name);
  endtask

  task automatic get_result(input string name, input longint s, input longint c, input longint o);
    int n = 0;
    wait_out_valid(name);
    chk({name, "_sum"}, out_sum, s);
    chk({name, "_count"}, out_count, c);
    chk({name, "_ovf"}, out_ovf, o);
    while (out_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_timeout({name, "_drain"});
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_mul_a", mul_a, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single pair
    send_pair(8'd3, 8'd5, 1'b1);
    get_result("single", 15, 1, 0);
    chk("single_pulses", pulses, 1);

    // Three-pair group
    send_pair(8'd10, 8'd20, 1'b0);
    send_pair(8'd7, 8'd7, 1'b0);
    send_pair(8'd255, 8'd1, 1'b1);
    get_result("three", 504, 3, 0);

    // Accumulator overflow, then a clean group
    send_pair(8'd255, 8'd255, 1'b0);
    send_pair(8'd255, 8'd255, 1'b1);
    get_result("acc_ovf", 64514, 2, 1);
    send_pair(8'd2, 8'd2, 1'b1);
    get_result("after_ovf", 4, 1, 0);

    // Zero operands still count as a pair
    send_pair(8'd0, 8'd9, 1'b0);
    send_pair(8'd6, 8'd0, 1'b1);
    get_result("zeros", 0, 2, 0);

    // Backpressure on the result port
    forced_ready = 1'b0;
    @(negedge clk);
    send_pair(8'd2, 8'd3, 1'b1);
    wait_out_valid("bp_wait");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a = 8'd99;
      in_b = 8'd99;
      in_last = 1'b1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_sum", out_sum, 6);
      chk("bp_count", out_count, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    forced_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);

    // Count saturation
    for (int i = 0; i < 5; i++) send_pair(8'd1, 8'd1, i == 4);
    get_result("sat", 5, 3, 1);

    // Reset during WAIT_DONE
    send_pair(8'd9, 8'd9, 1'b0);
    begin
      int n = 0;
      while (mul_done && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) fail_timeout("rst_wait_busy");
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_mul_start", mul_start, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_sum", out_sum, 0);
    chk("midrst_out_count", out_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_pair(8'd4, 8'd4, 1'b1);
    get_result("post_rst", 16, 1, 0);

    // Randomized groups with random consumer backpressure
    rand_mode = 1'b1;
    for (int g = 0; g < 40; g++) begin
      int len = $urandom_range(1, 6);
      for (int p = 0; p < len; p++) begin
        logic [W-1:0] a, b;
        a = ($urandom_range(0, 3) == 0) ? 8'd255 : W'($urandom_range(0, 255));
        b = ($urandom_range(0, 3) == 0) ? 8'd255 : W'($urandom_range(0, 255));
        send_pair(a, b, p == len - 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    begin
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 1000) fail_timeout("random_drain");
    end
    rand_mode = 1'b0;
    repeat (3) @(negedge clk);

    chk("pulses_vs_handshakes", pulses, handshakes);
    chk("results_pending", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_accum_seq.md
# mul_accum_seq

Sequencer that sits directly upstream and downstream of the 8-bit shift-add sequential multiplier.
- Accepts a stream of operand pairs over a valid/ready handshake.
- Launches one multiplication per pair and waits on the multiplier's done flag.
- Adds each product into an accumulator.
- On the pair flagged last, presents the group sum, pair count and overflow flag on a valid/ready output port.
- Provides the datapath a multiply-accumulate (dot-product) service without the producer knowing multiplier latency.

## Interface
- W, 8, operand width; product width is 2W
- ACC_W, 20, accumulator width (ACC_W ≥ 2W)
- LEN_W, 4, pair-count width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept a pair
- in_a, in_b  in  W  operands
- in_last  in  1  pair closes the current group
- mul_start  out  1  start pulse to multiplier
- mul_a, mul_b  out  W  registered operands to multiplier
- mul_done  in  1  multiplier idle/done flag (high when idle)
- mul_p  in  2W  multiplier product
- out_valid  out  1  group result present
- out_ready  in  1  consumer accepts result
- out_sum  out  ACC_W  group sum (mod 2^ACC_W)
- out_count  out  LEN_W  pairs in group (saturating)
- out_ovf  out  1  sum or count overflowed in this group

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, ACC, OUT.
- Reset (rst=1, async) values:
  - Datapath registers: state=IDLE; acc=0, cnt=0, ovf=0; mul_a=mul_b=0; last_r=0.
  - Outputs: mul_start=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_a→mul_a, in_b→mul_b, in_last→last_r; go START.
- START:
  - mul_start=1 for exactly this one cycle; go WAIT_BUSY.
- WAIT_BUSY:
  - Stay while mul_done=1.
  - On mul_done=0, go WAIT_DONE.
- WAIT_DONE:
  - Stay while mul_done=0.
  - On mul_done=1, go ACC.
- ACC:
  - Register updates: acc ← acc + zero-extended mul_p, computed in ACC_W+1 bits. Carry-out sets ovf (sticky).
  - Counter update: cnt ← cnt+1, saturating at 2^LEN_W−1. A saturating increment sets ovf.
  - If last_r=0: go IDLE.
  - If last_r=1: load out_sum/out_count/out_ovf with the updated values, then go OUT.
- OUT:
  - out_valid=1; in_ready=0.
  - out_sum, out_count and out_ovf are held stable while out_ready=0.
  - On out_ready=1: clear acc, cnt and ovf; go IDLE. out_valid deasserts the next cycle.
- mul_a/mul_b change only on input handshake; they are stable from START through ACC.
- mul_start is never asserted outside START.
- in_ready is a combinational decode of state==IDLE.
- Boundary conditions:
  - in_valid with in_ready=0: ignored; producer must hold the pair.
  - Zero operands: treated normally; product 0 still counts as a pair.
  - Single-pair group: in_last on the first pair gives out_count=1.
  - Reset mid-operation: immediate return to reset values. Any in-flight product is discarded. Multiplier recovery is its own reset's concern.
  - in_last=0 forever: accumulation continues; count saturates with ovf=1.

## Timing
- Input handshake at edge k:
  - START in cycle k+1 (mul_start high).
  - WAIT_BUSY from k+2.
- Multiplier lowers mul_done one cycle after sampling mul_start:
  - WAIT_BUSY lasts 1 cycle.
  - WAIT_DONE lasts the multiplier's busy duration B.
- ACC occupies one cycle after mul_done rises.
- Pair-to-pair throughput: 4 + B cycles (IDLE, START, WAIT_BUSY, ACC + busy).
- out_valid rises the cycle after ACC of the last pair.
- Minimum OUT residency: 1 cycle (out_ready already high).
- out_sum/out_count/out_ovf are registered (no combinational path from inputs).

## Test plan
- Single pair: in_a=3, in_b=5, in_last=1, out_ready=1 → exactly one mul_start pulse, mul_a=3, mul_b=5. Model returns mul_p=15 → out_sum=15, out_count=1, out_ovf=0.
- Three-pair group: (10,20), (7,7), (255,1), last on third → out_sum=504, out_count=3. in_ready is low from handshake until ACC completes for each pair.
- Overflow with ACC_W=16: (255,255) twice, last on second → out_sum=64514, out_count=2, out_ovf=1. Next group (2,2) → out_sum=4, out_ovf=0.
- Backpressure: out_ready low for 5 cycles after out_valid → out_sum/out_count held; in_ready=0 and in_valid ignored throughout. out_ready=1 → IDLE next cycle.
- Count saturation with LEN_W=2: five pairs (1,1), last on fifth → out_count=3, out_ovf=1, out_sum=5.
- Reset mid-op: assert rst during WAIT_DONE → same cycle mul_start=0, out_valid=0, in_ready=1. Next group (4,4) → out_sum=16, out_count=1.
